// File: rtl/bcd_display_scan_if.sv
// Bus between a score source and the multiplexed seven-segment scanner:
// packed BCD capture on one side, registered display pins on the other.
interface bcd_display_scan_if #(
    parameter int DIGITS = 2
);
    logic [4*DIGITS-1:0] bcd;
    logic                load;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   digit_sel;
    logic                frame_tc;

    modport master (
        output bcd,
        output load,
        input  seg,
        input  digit_sel,
        input  frame_tc
    );

    modport slave (
        input  bcd,
        input  load,
        output seg,
        output digit_sel,
        output frame_tc
    );
endinterface

// File: rtl/bcd_display_scan.sv
// Time-sliced seven-segment scanner: one digit per slot, a dead clock at the start
// of every slot, leading-zero blanking and frame-aligned (tear-free) value updates.
module bcd_display_scan #(
    parameter int DIGITS        = 2,
    parameter int SCAN_DIV      = 1000,
    parameter bit SEG_ACT_LOW   = 1'b1,
    parameter bit DIG_ACT_LOW   = 1'b1,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    bcd_display_scan_if.slave  bus
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF  = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] DIG_OFF  = DIG_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // The counters always describe the slot clock currently visible on the pins;
    // the output flops are loaded from the position being entered.
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [4*DIGITS-1:0] shadow_reg;
    logic [4*DIGITS-1:0] active_reg;
    logic [6:0]          seg_reg, seg_next;
    logic [DIGITS-1:0]   sel_reg, sel_next;
    logic                frame_tc_reg, frame_tc_next;

    logic [3:0]          digit_val [DIGITS];
    logic [DIGITS-1:0]   onehot;
    logic [DIGITS-1:0]   blank;
    logic [3:0]          cur_digit;
    logic                show;
    logic                zero_run;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_val[gi] = active_reg[4*gi +: 4];
            assign onehot[gi]    = (idx_next == IDX_W'(gi));
        end
    endgenerate

    // Walk down from the top digit; a digit is blanked while everything from it upward is zero.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run & (digit_val[i] == 4'd0);
            blank[i] = BLANK_LEADING & zero_run;
        end
    end

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        idx_next = idx_reg;
        if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
    end

    always_comb begin
        cur_digit     = digit_val[idx_next];
        show          = (cnt_next != '0) && !blank[idx_next];
        seg_next      = SEG_OFF;
        sel_next      = DIG_OFF;
        frame_tc_next = (cnt_next == CNT_LAST) && (idx_next == IDX_LAST);
        if (show) begin
            seg_next = SEG_ACT_LOW ? ~decode(cur_digit) : decode(cur_digit);
            sel_next = DIG_ACT_LOW ? ~onehot : onehot;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg      <= '0;
            idx_reg      <= '0;
            shadow_reg   <= '0;
            active_reg   <= '0;
            seg_reg      <= SEG_OFF;
            sel_reg      <= DIG_OFF;
            frame_tc_reg <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            seg_reg      <= seg_next;
            sel_reg      <= sel_next;
            frame_tc_reg <= frame_tc_next;
            if (bus.load) begin
                shadow_reg <= bus.bcd;
            end
            // Only the edge closing a frame refreshes the displayed value, and that
            // edge enters a dead clock, so no slot ever shows a mixed value.
            if (frame_tc_reg) begin
                active_reg <= shadow_reg;
            end
        end
    end

    assign bus.seg       = seg_reg;
    assign bus.digit_sel = sel_reg;
    assign bus.frame_tc  = frame_tc_reg;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for the display scanner (2 digits, 4 clocks per slot, active-low pins),
// checking every sampled clock against a queued expectation from a small frame model.
module tb_bcd_display_scan;

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] sel;
        logic       ftc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    exp_t       sb_q[$];
    int         pos;
    logic [7:0] shadow_m;
    logic [7:0] active_m;

    bcd_display_scan_if #(.DIGITS(2)) bus ();

    bcd_display_scan #(
        .DIGITS        (2),
        .SCAN_DIV      (4),
        .SEG_ACT_LOW   (1'b1),
        .DIG_ACT_LOW   (1'b1),
        .BLANK_LEADING (1'b1)
    ) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Expected pins for frame position p (0..7) while the active value is act.
    function automatic exp_t model(input int p, input logic [7:0] act);
        exp_t       e;
        int         slot;
        int         c;
        logic [3:0] d;
        slot  = p / 4;
        c     = p % 4;
        e.seg = 7'h7F;
        e.sel = 2'b11;
        e.ftc = (p == 7);
        d     = (slot == 0) ? act[3:0] : act[7:4];
        if (c != 0 && !(slot == 1 && act[7:4] == 4'd0)) begin
            e.seg = ~seg_pattern(d);
            e.sel = (slot == 0) ? 2'b10 : 2'b01;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
        vectors++;
        assert (obs === req)
        else begin
            miscompares++;
            $error("FAIL %s: got %h, expected %h", tag, obs, req);
        end
    endtask

    task automatic check_pins(input string tag, input exp_t e);
        chk({tag, ".seg"}, {1'b0, bus.seg}, {1'b0, e.seg});
        chk({tag, ".digit_sel"}, {6'd0, bus.digit_sel}, {6'd0, e.sel});
        chk({tag, ".frame_tc"}, {7'd0, bus.frame_tc}, {7'd0, e.ftc});
    endtask

    // One clock: drive load/bcd, advance the model, queue the expectation,
    // then compare against the DUT on the following falling edge.
    task automatic tick(input logic do_load, input logic [7:0] v);
        exp_t e;
        bus.load = do_load;
        bus.bcd  = v;
        if (pos == 7) active_m = shadow_m;
        if (do_load) shadow_m = v;
        pos = (pos + 1) % 8;
        sb_q.push_back(model(pos, active_m));
        @(negedge clk);
        e = sb_q.pop_front();
        check_pins($sformatf("pos%0d act%h", pos, active_m), e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 8'h00);
    endtask

    task automatic align(input int p);
        for (int k = 0; k < 8 && pos != p; k++) tick(1'b0, 8'h00);
    endtask

    initial begin
        bus.load = 1'b0;
        bus.bcd  = 8'h00;
        pos      = 0;
        shadow_m = 8'h00;
        active_m = 8'h00;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check_pins("reset", exp_t'{seg: 7'h7F, sel: 2'b11, ftc: 1'b0});
        reset = 1'b0;
        #1;
        check_pins("release", model(0, 8'h00));

        // Free-running scan with value 0: digit0 shows "0", digit1 blanked, frame_tc on clock 7.
        idle(16);

        // Value 42: appears after the next frame_tc.
        align(3);
        tick(1'b1, 8'h42);
        idle(20);

        // 07 (digit1 blanked), 00 (only digit0), 3B (dash + 3).
        tick(1'b1, 8'h07);
        idle(16);
        tick(1'b1, 8'h00);
        idle(16);
        tick(1'b1, 8'h3B);
        idle(16);

        // Load in slot0: current frame still shows 3B.
        align(1);
        tick(1'b1, 8'h11);
        idle(12);

        // Load coincident with frame_tc: old shadow goes active, new value waits a frame.
        tick(1'b1, 8'h56);
        align(7);
        tick(1'b1, 8'h95);
        idle(16);

        // Asynchronous reset in the middle of slot 1.
        align(5);
        reset = 1'b1;
        #1;
        check_pins("async_reset", exp_t'{seg: 7'h7F, sel: 2'b11, ftc: 1'b0});
        @(negedge clk);
        check_pins("reset_hold", exp_t'{seg: 7'h7F, sel: 2'b11, ftc: 1'b0});
        reset    = 1'b0;
        pos      = 0;
        shadow_m = 8'h00;
        active_m = 8'h00;
        tick(1'b0, 8'h00);
        chk("first_digit_after_reset", {6'd0, bus.digit_sel}, 8'h02);
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
